// File: rtl/stopwatch_seq.sv
// stopwatch_seq: button front end, run/lap/pause FSM, tick prescaler,
// cs/sec/min cascade and lap-freezable display registers.
// Optional macro SW_WRAP_EN: wrap 59:59.99 -> 00:00.00 instead of saturating.
module stopwatch_seq #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [1:0] state,
    output logic       run,
    output logic [6:0] cs,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [6:0] disp_cs,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic       ovf
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("stopwatch_seq: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_LAP   = 2'b10,
        ST_PAUSE = 2'b11
    } state_e;

    // bit 0 start, bit 1 clear, bit 2 lap
    logic [2:0] btn_raw;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] prev_q, prev_d;
    logic [2:0] btn_rise;
    logic       start_p, clear_p, lap_p;

    state_e     state_q, state_d;
    logic       run_q, run_d;
    logic       clr;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          at_top;

    logic [6:0] cs_q, cs_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic       ovf_q, ovf_d;

    logic [6:0] dcs_q, dcs_d;
    logic [5:0] dsec_q, dsec_d;
    logic [5:0] dmin_q, dmin_d;

    assign btn_raw  = {btn_lap, btn_clear, btn_start};
    assign btn_rise = sync2_q & ~prev_q;
    assign start_p  = btn_rise[0];
    assign clear_p  = btn_rise[1];
    assign lap_p    = btn_rise[2];

    // two-stage synchroniser chain plus previous-value stage per button
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // synchroniser and edge-detect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // next-state decode; start outranks clear and lap
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        unique case (state_q)
            ST_STOP: begin
                if (start_p) begin
                    state_d = ST_RUN;
                end else if (clear_p) begin
                    clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_p) begin
                    state_d = ST_PAUSE;
                end else if (lap_p) begin
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (lap_p) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (start_p) begin
                    state_d = ST_RUN;
                end else if (clear_p) begin
                    state_d = ST_STOP;
                    clr     = 1'b1;
                end
            end
            default: state_d = ST_STOP;
        endcase
        run_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    end

    // FSM state and its registered run flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign tick   = run_q && (presc_q == PRESC_MAX);
    assign at_top = (cs_q == 7'd99) && (sec_q == 6'd59) && (min_q == 6'd59);

    // prescaler and time cascade; clear only happens while stopped/paused
    always_comb begin
        presc_d = presc_q;
        cs_d    = cs_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ovf_d   = ovf_q;
        if (clr) begin
            presc_d = '0;
            cs_d    = '0;
            sec_d   = '0;
            min_d   = '0;
            ovf_d   = 1'b0;
        end else if (run_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (at_top) begin
`ifdef SW_WRAP_EN
                    cs_d  = '0;
                    sec_d = '0;
                    min_d = '0;
`endif
                    ovf_d = 1'b1;
                end else if (cs_q == 7'd99) begin
                    cs_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        min_d = min_q + 6'd1;
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    cs_d = cs_q + 7'd1;
                end
            end
        end
    end

    // prescaler, live counters and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cs_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cs_q    <= cs_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            ovf_q   <= ovf_d;
        end
    end

    // display tracks the live count one cycle late, frozen while in lap
    always_comb begin
        dcs_d  = dcs_q;
        dsec_d = dsec_q;
        dmin_d = dmin_q;
        if (state_q != ST_LAP) begin
            dcs_d  = cs_q;
            dsec_d = sec_q;
            dmin_d = min_q;
        end
    end

    // display registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcs_q  <= '0;
            dsec_q <= '0;
            dmin_q <= '0;
        end else begin
            dcs_q  <= dcs_d;
            dsec_q <= dsec_d;
            dmin_q <= dmin_d;
        end
    end

    assign state    = state_q;
    assign run      = run_q;
    assign cs       = cs_q;
    assign sec      = sec_q;
    assign min      = min_q;
    assign disp_cs  = dcs_q;
    assign disp_sec = dsec_q;
    assign disp_min = dmin_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_seq.sv
// tb_stopwatch_seq: directed stimulus with a cycle-tagged scoreboard;
// expectations are queued ahead and a negedge monitor compares them.
module tb_stopwatch_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic [1:0] state;
    logic       run;
    logic [6:0] cs;
    logic [5:0] sec;
    logic [5:0] min;
    logic [6:0] disp_cs;
    logic [5:0] disp_sec;
    logic [5:0] disp_min;
    logic       ovf;

    stopwatch_seq #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .btn_lap  (btn_lap),
        .state    (state),
        .run      (run),
        .cs       (cs),
        .sec      (sec),
        .min      (min),
        .disp_cs  (disp_cs),
        .disp_sec (disp_sec),
        .disp_min (disp_min),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    localparam int S_ST   = 0;
    localparam int S_RUN  = 1;
    localparam int S_CS   = 2;
    localparam int S_SEC  = 3;
    localparam int S_MIN  = 4;
    localparam int S_DCS  = 5;
    localparam int S_DSEC = 6;
    localparam int S_DMIN = 7;
    localparam int S_OVF  = 8;

    localparam int B_START = 0;
    localparam int B_CLEAR = 1;
    localparam int B_LAP   = 2;

    typedef struct {
        int    at;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    // cycle index: stable between a posedge and the following negedge
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int probe(input int sel);
        case (sel)
            S_ST:    return int'(state);
            S_RUN:   return int'(run);
            S_CS:    return int'(cs);
            S_SEC:   return int'(sec);
            S_MIN:   return int'(min);
            S_DCS:   return int'(disp_cs);
            S_DSEC:  return int'(disp_sec);
            S_DMIN:  return int'(disp_min);
            default: return int'(ovf);
        endcase
    endfunction

    function automatic void chk(input int at, input int sel,
                                input int val, input string name);
        exp_t e;
        e.at   = at;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sbq.push_back(e);
    endfunction

    function automatic void chk_zero(input int at, input string tag);
        chk(at, S_ST,   0, {tag, "_state"});
        chk(at, S_RUN,  0, {tag, "_run"});
        chk(at, S_CS,   0, {tag, "_cs"});
        chk(at, S_SEC,  0, {tag, "_sec"});
        chk(at, S_MIN,  0, {tag, "_min"});
        chk(at, S_DCS,  0, {tag, "_dcs"});
        chk(at, S_DSEC, 0, {tag, "_dsec"});
        chk(at, S_DMIN, 0, {tag, "_dmin"});
        chk(at, S_OVF,  0, {tag, "_ovf"});
    endfunction

    // monitor: compare every expectation due in this cycle
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at <= cyc) begin
                n_chk++;
                if (sbq[i].at < cyc) begin
                    $display("FAIL %s: slot %0d missed at cycle %0d",
                             sbq[i].name, sbq[i].at, cyc);
                end else if (probe(sbq[i].sel) == sbq[i].val) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                             sbq[i].name, probe(sbq[i].sel),
                             sbq[i].val, cyc);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic press(input int which);
        case (which)
            B_START: btn_start = 1'b1;
            B_CLEAR: btn_clear = 1'b1;
            default: btn_lap = 1'b1;
        endcase
        @(negedge clk);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // start from STOP; e is the clock edge where RUN is entered
    task automatic go(output int e);
        int b;
        b = cyc;
        press(B_START);
        e = b + 3;
    endtask

    initial begin
        int b;
        int e;
        int q;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero(cyc + 1, "reset");

        // held start: one transition, two-edge latency, first tick at DIV
        wait_until(cyc + 2);
        b = cyc;
        btn_start = 1'b1;
        chk(b + 2,  S_ST,  0, "s1_state_early");
        chk(b + 3,  S_ST,  1, "s1_state_run");
        chk(b + 3,  S_RUN, 1, "s1_run");
        chk(b + 8,  S_ST,  1, "s1_state_held");
        chk(b + 12, S_CS,  0, "s1_cs_pre");
        chk(b + 13, S_CS,  1, "s1_cs_first");
        wait_until(b + 3);
        btn_start = 1'b0;
        e = b + 3;

        // 1000 cycles -> 00:01.00, then pause/resume with held prescaler
        chk(e + 999,  S_CS,  99, "s2_cs_99");
        chk(e + 1000, S_CS,  0,  "s2_cs_wrap");
        chk(e + 1000, S_SEC, 1,  "s2_sec");
        chk(e + 1000, S_MIN, 0,  "s2_min");
        chk(e + 1001, S_DSEC, 1, "s2_dsec");
        chk(e + 1003, S_ST,  3,  "s2_pause");
        chk(e + 1003, S_RUN, 0,  "s2_run_off");
        chk(e + 1053, S_CS,  0,  "s2_cs_hold");
        chk(e + 1053, S_SEC, 1,  "s2_sec_hold");
        chk(e + 1063, S_ST,  1,  "s2_resume");
        chk(e + 1069, S_CS,  0,  "s2_cs_remain");
        chk(e + 1070, S_CS,  1,  "s2_cs_tick");
        wait_until(e + 1000);
        press(B_START);
        wait_until(e + 1060);
        press(B_START);
        wait_until(e + 1075);

        // lap freezes display while counting continues
        do_reset();
        go(e);
        chk(e + 253, S_ST,  2,  "s3_lap");
        chk(e + 253, S_CS,  25, "s3_cs25");
        chk(e + 253, S_DCS, 25, "s3_dcs_latch");
        chk(e + 270, S_CS,  27, "s3_cs_moving");
        chk(e + 270, S_DCS, 25, "s3_dcs_frozen");
        chk(e + 270, S_RUN, 1,  "s3_run_lap");
        chk(e + 405, S_ST,  2,  "s3_clear_ign");
        chk(e + 425, S_ST,  2,  "s3_start_ign");
        chk(e + 425, S_CS,  42, "s3_cs42");
        chk(e + 425, S_DCS, 25, "s3_dcs_still");
        chk(e + 553, S_ST,  1,  "s3_unlap");
        chk(e + 553, S_DCS, 25, "s3_dcs_lag");
        chk(e + 554, S_DCS, 55, "s3_dcs_follow");
        chk(e + 554, S_CS,  55, "s3_cs55");
        wait_until(e + 250);
        press(B_LAP);
        wait_until(e + 400);
        press(B_CLEAR);
        wait_until(e + 420);
        press(B_START);
        wait_until(e + 550);
        press(B_LAP);
        wait_until(e + 560);

        // pause at 00:03.40, clear, clear again, restart from zero
        do_reset();
        go(e);
        q = e + 3410;
        chk(e + 3401, S_ST,  3,  "s4_pause");
        chk(e + 3401, S_CS,  40, "s4_cs40");
        chk(e + 3401, S_SEC, 3,  "s4_sec3");
        chk(e + 3401, S_MIN, 0,  "s4_min0");
        chk(q + 3, S_ST,   0,  "s4_stop");
        chk(q + 3, S_CS,   0,  "s4_cs_clr");
        chk(q + 3, S_SEC,  0,  "s4_sec_clr");
        chk(q + 3, S_DCS,  40, "s4_dcs_lag");
        chk(q + 3, S_DSEC, 3,  "s4_dsec_lag");
        chk(q + 4, S_DCS,  0,  "s4_dcs_clr");
        chk(q + 4, S_DSEC, 0,  "s4_dsec_clr");
        chk(q + 4, S_OVF,  0,  "s4_ovf");
        chk(q + 4, S_RUN,  0,  "s4_run");
        chk(q + 13, S_ST,  0,  "s4_stop_again");
        chk(q + 13, S_CS,  0,  "s4_cs_again");
        chk(q + 23, S_ST,  1,  "s4_restart");
        chk(q + 32, S_CS,  0,  "s4_presc_zero");
        chk(q + 33, S_CS,  1,  "s4_first_tick");
        wait_until(e + 3398);
        press(B_START);
        wait_until(q);
        press(B_CLEAR);
        wait_until(q + 10);
        press(B_CLEAR);
        wait_until(q + 20);
        press(B_START);
        wait_until(q + 35);

        // start and lap in the same cycle: start wins, no lap entry
        do_reset();
        go(e);
        chk(e + 53, S_ST,  3, "s5_pause");
        chk(e + 53, S_RUN, 0, "s5_run");
        chk(e + 53, S_CS,  5, "s5_cs");
        chk(e + 54, S_DCS, 5, "s5_dcs");
        chk(e + 73, S_ST,  3, "s5_lap_ign");
        wait_until(e + 50);
        btn_lap = 1'b1;
        press(B_START);
        wait_until(e + 70);
        press(B_LAP);
        wait_until(e + 75);

        // terminal count, then asynchronous reset mid-run
        do_reset();
        go(e);
        chk(e + 18, S_ST,  3,  "s6_pause");
        chk(e + 22, S_CS,  99, "s6_cs_set");
        chk(e + 22, S_SEC, 59, "s6_sec_set");
        chk(e + 22, S_MIN, 59, "s6_min_set");
        chk(e + 22, S_DCS, 99, "s6_dcs_set");
        chk(e + 22, S_OVF, 0,  "s6_ovf_pre");
        chk(e + 29, S_CS,  99, "s6_cs_pre");
        chk(e + 29, S_OVF, 0,  "s6_ovf_pre2");
`ifdef SW_WRAP_EN
        chk(e + 30, S_CS,  0,  "s6_wrap_cs");
        chk(e + 30, S_SEC, 0,  "s6_wrap_sec");
        chk(e + 30, S_MIN, 0,  "s6_wrap_min");
        chk(e + 40, S_CS,  1,  "s6_wrap_cont");
`else
        chk(e + 30, S_CS,  99, "s6_sat_cs");
        chk(e + 30, S_SEC, 59, "s6_sat_sec");
        chk(e + 30, S_MIN, 59, "s6_sat_min");
        chk(e + 40, S_CS,  99, "s6_sat_hold");
`endif
        chk(e + 30, S_OVF, 1,  "s6_ovf_set");
        chk(e + 40, S_OVF, 1,  "s6_ovf_sticky");
        chk(e + 40, S_ST,  1,  "s6_still_run");
        chk_zero(e + 46, "s6_rst");
        wait_until(e + 15);
        press(B_START);
        wait_until(e + 20);
        force dut.cs_q = 7'd99;
        force dut.sec_q = 6'd59;
        force dut.min_q = 6'd59;
        @(negedge clk);
        release dut.cs_q;
        release dut.sec_q;
        release dut.min_q;
        wait_until(e + 25);
        press(B_START);
        wait_until(e + 45);
        rst = 1'b1;
        wait_until(e + 47);
        rst = 1'b0;

        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
            @(negedge clk);
        end
        while (sbq.size() != 0) begin
            n_chk++;
            $display("FAIL %s: never checked, expected %0d",
                     sbq[0].name, sbq[0].val);
            sbq.delete(0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
